// File: rtl/flash_pkg.sv
// Shared types for the flash slave command/address front end.
//   lane_mode_e : IO lane width selector (x1/x2/x4/x8)
//   cap_state_e : capture FSM states
//   lanes()     : number of IO pins sampled per sck edge for a lane mode
package flash_pkg;

    typedef enum logic [1:0] {
        LANE_X1,
        LANE_X2,
        LANE_X4,
        LANE_X8
    } lane_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        OPCODE,
        ADDR,
        DONE
    } cap_state_e;

    // Map a lane mode onto the number of bits shifted in per edge.
    function automatic logic [3:0] lanes(input lane_mode_e mode);
        case (mode)
            LANE_X1: lanes = 4'd1;
            LANE_X2: lanes = 4'd2;
            LANE_X4: lanes = 4'd4;
            default: lanes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/flash_lane_shifter.sv
// Variable-lane, MSB-first shift register with a bit counter.
// Each shifting edge pushes L = lanes(mode_i) bits of data_i into the
// bottom of the register and advances the counter by L.
//   sck_i        capture clock (rising edge)
//   rst_i        synchronous active-high reset
//   clear_i      synchronous clear of register and counter
//   shift_i      shift one sample this edge (ignored while clearing)
//   mode_i       lane mode used for this sample
//   data_i       pin data, lanes taken from the low bits
//   sr_next_o    register value including the current sample
//   cnt_next_o   bit count including the current sample
module flash_lane_shifter
    import flash_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = $clog2(W) + 1
) (
    input  logic          sck_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          shift_i,
    input  lane_mode_e    mode_i,
    input  logic [7:0]    data_i,
    output logic [W-1:0]  sr_next_o,
    output logic [CW-1:0] cnt_next_o
);

    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    lane_cnt;
    logic [7:0]    lane_mask;

    // Look-ahead values: the top uses them to detect a phase completing on
    // this very edge, so the captured byte includes the last sample.
    always_comb begin
        lane_cnt  = lanes(mode_i);
        lane_mask = 8'((9'd1 << lane_cnt) - 9'd1);
        sr_d      = (sr_q << lane_cnt) | W'(data_i & lane_mask);
        cnt_d     = cnt_q + CW'(lane_cnt);
    end

    // Clear wins over shift so every phase starts from an all-zero register,
    // which is what makes the captured address come out zero-extended.
    always_ff @(posedge sck_i) begin
        if (rst_i || clear_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (shift_i) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr_next_o  = sr_d;
    assign cnt_next_o = cnt_d;

endmodule

// File: rtl/flash_cmd_addr_capture.sv
// Command/address capture front end for the flash slave.
// Collects a 1- or 2-byte opcode (2-byte form = opcode, ~opcode) followed by
// 0..ADDR_BYTES_MAX address bytes from the IO pins, MSB first, x1/x2/x4/x8.
//   sck_i          capture clock, rising edge
//   rst_i          synchronous active-high reset
//   lane_mode_i    0=x1 1=x2 2=x4 3=x8, latched at frame start
//   addr_bytes_i   address bytes for the frame, latched at frame start, clamped
//   en_frame_i     io_in_i valid this edge; low ends/aborts the frame
//   io_in_i        pin data
//   op_o           last accepted opcode (first byte)
//   addr_o         last captured address, right-aligned
//   op_valid_o     one-cycle pulse: opcode accepted
//   addr_valid_o   one-cycle pulse: address complete
//   op_err_o       one-cycle pulse: opcode complement mismatch
//   abort_o        one-cycle pulse: frame dropped before completion
//   busy_o         high while capturing opcode or address
module flash_cmd_addr_capture
    import flash_pkg::*;
#(
    parameter int OP_BYTES       = 1,
    parameter int ADDR_BYTES_MAX = 4
) (
    input  logic                        sck_i,
    input  logic                        rst_i,
    input  logic [1:0]                  lane_mode_i,
    input  logic [2:0]                  addr_bytes_i,
    input  logic                        en_frame_i,
    input  logic [7:0]                  io_in_i,
    output logic [7:0]                  op_o,
    output logic [8*ADDR_BYTES_MAX-1:0] addr_o,
    output logic                        op_valid_o,
    output logic                        addr_valid_o,
    output logic                        op_err_o,
    output logic                        abort_o,
    output logic                        busy_o
);

    localparam int AW  = 8 * ADDR_BYTES_MAX;
    localparam int OPW = 8 * OP_BYTES;
    localparam int W   = 8 * ((OP_BYTES > ADDR_BYTES_MAX) ? OP_BYTES : ADDR_BYTES_MAX);
    localparam int CW  = $clog2(W) + 1;

    cap_state_e    state_q, state_d;
    lane_mode_e    mode_q, mode_d;
    logic [2:0]    abytes_q, abytes_d, abytes_in, abytes_eff;
    logic [7:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          op_valid_q, op_valid_d;
    logic          addr_valid_q, addr_valid_d;
    logic          op_err_q, op_err_d;
    logic          abort_q, abort_d;
    logic          busy_q, busy_d;

    logic          shift;
    logic [W-1:0]  sr_next;
    logic [CW-1:0] cnt_next;
    logic [OPW-1:0] op_word;
    logic [7:0]    op_first, op_second;

    flash_lane_shifter #(
        .W  (W),
        .CW (CW)
    ) u_shifter (
        .sck_i      (sck_i),
        .rst_i      (rst_i),
        .clear_i    (~shift),
        .shift_i    (shift),
        .mode_i     (mode_d),
        .data_i     (io_in_i),
        .sr_next_o  (sr_next),
        .cnt_next_o (cnt_next)
    );

    // In IDLE the first enabled edge is already a data sample, so the live
    // lane mode and address length are used (and latched) on that edge;
    // afterwards the latched copies hold for the rest of the frame.
    always_comb begin
        abytes_in  = (int'(addr_bytes_i) > ADDR_BYTES_MAX) ? 3'(ADDR_BYTES_MAX) : addr_bytes_i;
        mode_d     = (state_q == IDLE) ? lane_mode_e'(lane_mode_i) : mode_q;
        abytes_eff = (state_q == IDLE) ? abytes_in : abytes_q;
        abytes_d   = abytes_eff;
    end

    // Next-state and output logic. The shifter keeps accumulating only while
    // a phase is in progress; any phase end, frame end or DONE clears it.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        op_valid_d   = 1'b0;
        addr_valid_d = 1'b0;
        op_err_d     = 1'b0;
        abort_d      = 1'b0;
        shift        = 1'b0;
        op_word      = sr_next[OPW-1:0];
        op_first     = op_word[OPW-1 -: 8];
        op_second    = op_word[7:0];

        if (!en_frame_i) begin
            if (state_q == OPCODE || state_q == ADDR) begin
                abort_d = 1'b1;
            end
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, OPCODE: begin
                    if (cnt_next == CW'(OPW)) begin
                        if (OP_BYTES == 2 && op_second != ~op_first) begin
                            op_err_d = 1'b1;
                            state_d  = DONE;
                        end else begin
                            op_d       = op_first;
                            op_valid_d = 1'b1;
                            state_d    = (abytes_eff != 3'd0) ? ADDR : DONE;
                        end
                    end else begin
                        shift   = 1'b1;
                        state_d = OPCODE;
                    end
                end
                ADDR: begin
                    if (cnt_next == CW'({abytes_q, 3'b000})) begin
                        addr_d       = sr_next[AW-1:0];
                        addr_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        shift = 1'b1;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == OPCODE) || (state_d == ADDR);
    end

    // State and output registers; reset discards any frame in progress.
    always_ff @(posedge sck_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mode_q       <= LANE_X1;
            abytes_q     <= 3'd0;
            op_q         <= 8'd0;
            addr_q       <= '0;
            op_valid_q   <= 1'b0;
            addr_valid_q <= 1'b0;
            op_err_q     <= 1'b0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            abytes_q     <= abytes_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            op_valid_q   <= op_valid_d;
            addr_valid_q <= addr_valid_d;
            op_err_q     <= op_err_d;
            abort_q      <= abort_d;
            busy_q       <= busy_d;
        end
    end

    assign op_o         = op_q;
    assign addr_o       = addr_q;
    assign op_valid_o   = op_valid_q;
    assign addr_valid_o = addr_valid_q;
    assign op_err_o     = op_err_q;
    assign abort_o      = abort_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_flash_cmd_addr_capture.sv
// Testbench for flash_cmd_addr_capture: two instances (1-byte and 2-byte
// opcode) share one set of pins and are compared every cycle against a
// frame-level model that just counts bits received in the current frame.
module tb_flash_cmd_addr_capture;

    logic        sck = 1'b0;
    logic        rst;
    logic [1:0]  laneMode;
    logic [2:0]  addrBytes;
    logic        enFrame;
    logic [7:0]  ioIn;

    logic [7:0]  op1, op2;
    logic [31:0] addr1, addr2;
    logic        opV1, opV2, addrV1, addrV2, err1, err2, abort1, abort2, busy1, busy2;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    // Model state, index 0 = 1-byte opcode instance, 1 = 2-byte instance.
    logic [7:0]  eOp[2];
    logic [31:0] eAddr[2];
    bit          eOpV[2], eAddrV[2], eErr[2], eAbort[2], eBusy[2];
    bit          mInFrame[2], mDead[2];
    int          mL[2], mAb[2], mN[2];
    logic [63:0] mAcc[2];

    always #5 sck = ~sck;

    flash_cmd_addr_capture #(.OP_BYTES(1), .ADDR_BYTES_MAX(4)) dut1 (
        .sck_i(sck), .rst_i(rst), .lane_mode_i(laneMode), .addr_bytes_i(addrBytes),
        .en_frame_i(enFrame), .io_in_i(ioIn), .op_o(op1), .addr_o(addr1),
        .op_valid_o(opV1), .addr_valid_o(addrV1), .op_err_o(err1), .abort_o(abort1),
        .busy_o(busy1)
    );

    flash_cmd_addr_capture #(.OP_BYTES(2), .ADDR_BYTES_MAX(4)) dut2 (
        .sck_i(sck), .rst_i(rst), .lane_mode_i(laneMode), .addr_bytes_i(addrBytes),
        .en_frame_i(enFrame), .io_in_i(ioIn), .op_o(op2), .addr_o(addr2),
        .op_valid_o(opV2), .addr_valid_o(addrV2), .op_err_o(err2), .abort_o(abort2),
        .busy_o(busy2)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Frame model: a frame is every enabled edge since en_frame last went low.
    // Opcode completes when the frame holds 8*opB bits, address when it holds
    // 8*(opB+ab) bits; after either terminal event the rest is ignored.
    task automatic modelStep(input int k, input int opB);
        int opBits;
        logic [7:0] b1, b2;
        opBits = 8 * opB;
        if (rst) begin
            eOp[k] = 8'd0; eAddr[k] = 32'd0;
            eOpV[k] = 0; eAddrV[k] = 0; eErr[k] = 0; eAbort[k] = 0; eBusy[k] = 0;
            mInFrame[k] = 0; mDead[k] = 0;
        end else begin
            eOpV[k] = 0; eAddrV[k] = 0; eErr[k] = 0; eAbort[k] = 0;
            if (enFrame) begin
                if (!mInFrame[k]) begin
                    mInFrame[k] = 1; mDead[k] = 0; mN[k] = 0; mAcc[k] = 64'd0;
                    mL[k]  = 1 << laneMode;
                    mAb[k] = (addrBytes > 3'd4) ? 4 : int'(addrBytes);
                end
                if (!mDead[k]) begin
                    mAcc[k] = (mAcc[k] << mL[k]) | (64'(ioIn) & ((64'd1 << mL[k]) - 64'd1));
                    mN[k]   = mN[k] + mL[k];
                    if (mN[k] == opBits) begin
                        b1 = 8'(mAcc[k] >> (opBits - 8));
                        b2 = 8'(mAcc[k]);
                        if (opB == 2 && b2 != ~b1) begin
                            eErr[k] = 1; mDead[k] = 1;
                        end else begin
                            eOp[k] = b1; eOpV[k] = 1;
                            if (mAb[k] == 0) mDead[k] = 1;
                        end
                    end else if (mN[k] > opBits && mN[k] == opBits + 8 * mAb[k]) begin
                        eAddr[k]  = 32'(mAcc[k] & ((64'd1 << (8 * mAb[k])) - 64'd1));
                        eAddrV[k] = 1; mDead[k] = 1;
                    end
                end
            end else begin
                if (mInFrame[k] && !mDead[k]) eAbort[k] = 1;
                mInFrame[k] = 0;
            end
        end
        eBusy[k] = mInFrame[k] && !mDead[k];
    endtask

    always @(posedge sck) begin
        modelStep(0, 1);
        modelStep(1, 2);
    end

    task automatic checkOutput(input int k, input logic [7:0] op, input logic [31:0] addr,
                               input logic opV, input logic addrV, input logic err,
                               input logic abt, input logic busy);
        string p;
        p = (k == 0) ? "dut1" : "dut2";
        checkVal({p, " op"}, 32'(op), 32'(eOp[k]));
        checkVal({p, " addr"}, addr, eAddr[k]);
        checkVal({p, " op_valid"}, 32'(opV), 32'(eOpV[k]));
        checkVal({p, " addr_valid"}, 32'(addrV), 32'(eAddrV[k]));
        checkVal({p, " op_err"}, 32'(err), 32'(eErr[k]));
        checkVal({p, " abort"}, 32'(abt), 32'(eAbort[k]));
        checkVal({p, " busy"}, 32'(busy), 32'(eBusy[k]));
    endtask

    // Every cycle, away from the active edge, both instances against the model.
    always @(negedge sck) begin
        if (checkEn) begin
            checkOutput(0, op1, addr1, opV1, addrV1, err1, abort1, busy1);
            checkOutput(1, op2, addr2, opV2, addrV2, err2, abort2, busy2);
        end
    end

    // Drive one edge's worth of pins, then return just after that edge.
    task automatic applyStimulus(input bit r, input bit e, input logic [7:0] io,
                                 input logic [1:0] lm, input logic [2:0] ab);
        rst = r; enFrame = e; ioIn = io; laneMode = lm; addrBytes = ab;
        @(posedge sck);
        #1;
    endtask

    // Send edge i of an nbits-long MSB-first stream in lane mode lm.
    task automatic sendEdge(input logic [63:0] data, input int nbits, input logic [1:0] lm,
                            input logic [2:0] ab, input int i);
        int L;
        logic [63:0] chunk;
        L = 1 << lm;
        chunk = (data >> (nbits - L * (i + 1))) & ((64'd1 << L) - 64'd1);
        applyStimulus(0, 1, 8'(chunk), lm, ab);
    endtask

    task automatic endFrame();
        applyStimulus(0, 0, 8'h00, 2'd0, 3'd0);
    endtask

    initial begin
        logic [7:0]  b0, b1;
        logic [63:0] data;
        int L, len;

        rst = 1; enFrame = 0; ioIn = 0; laneMode = 0; addrBytes = 0;
        applyStimulus(1, 0, 8'h00, 2'd0, 3'd0);
        applyStimulus(1, 0, 8'h00, 2'd0, 3'd0);
        checkVal("reset op", 32'(op1), 32'h0);
        checkVal("reset addr", addr1, 32'h0);
        checkVal("reset busy", 32'(busy2), 32'h0);
        checkEn = 1'b1;
        endFrame();

        // x1, 1-byte opcode 0x9F, no address
        for (int i = 0; i < 8; i++) begin
            sendEdge(64'h9F, 8, 2'd0, 3'd0, i);
            if (i == 6) checkVal("x1 op_valid early", 32'(opV1), 32'h0);
        end
        checkVal("x1 op 9F", 32'(op1), 32'h9F);
        checkVal("x1 op_valid", 32'(opV1), 32'h1);
        checkVal("x1 no addr_valid", 32'(addrV1), 32'h0);
        endFrame();
        checkVal("x1 op_valid one cycle", 32'(opV1), 32'h0);
        checkVal("dut2 short opcode abort", 32'(abort2), 32'h1);

        // x1, opcode 0x03 + 3-byte address 0x123456
        for (int i = 0; i < 32; i++) begin
            sendEdge(64'h03123456, 32, 2'd0, 3'd3, i);
            if (i == 7) checkVal("x1 read op_valid", 32'(opV1), 32'h1);
        end
        checkVal("x1 read addr", addr1, 32'h00123456);
        checkVal("x1 read addr_valid", 32'(addrV1), 32'h1);
        endFrame();

        // x8, 2-byte opcode EE/11, 4-byte address
        for (int i = 0; i < 6; i++) begin
            sendEdge(64'hEE11DEADBEEF, 48, 2'd3, 3'd4, i);
            if (i == 1) begin
                checkVal("x8 op EE", 32'(op2), 32'hEE);
                checkVal("x8 op_valid", 32'(opV2), 32'h1);
            end
        end
        checkVal("x8 addr", addr2, 32'hDEADBEEF);
        checkVal("x8 addr_valid", 32'(addrV2), 32'h1);
        endFrame();

        // x8, bad complement EE/12, trailing bytes must be ignored
        for (int i = 0; i < 6; i++) begin
            sendEdge(64'hEE12AABBCCDD, 48, 2'd3, 3'd4, i);
            if (i == 1) begin
                checkVal("x8 op_err", 32'(err2), 32'h1);
                checkVal("x8 err no op_valid", 32'(opV2), 32'h0);
            end
        end
        checkVal("x8 err op unchanged", 32'(op2), 32'hEE);
        checkVal("x8 err addr unchanged", addr2, 32'hDEADBEEF);
        endFrame();

        // x4, opcode 0x0B + 3-byte address, dropped after 5 edges
        for (int i = 0; i < 5; i++) sendEdge(64'h0B112233, 32, 2'd2, 3'd3, i);
        endFrame();
        checkVal("x4 abort", 32'(abort1), 32'h1);
        checkVal("x4 abort busy", 32'(busy1), 32'h0);
        checkVal("x4 abort addr kept", addr1, 32'h12AABBCC);

        // reset in the middle of an address phase, then a fresh x2 frame
        for (int i = 0; i < 12; i++) sendEdge(64'h03123456, 32, 2'd0, 3'd3, i);
        applyStimulus(1, 1, 8'hFF, 2'd0, 3'd3);
        checkVal("mid rst op", 32'(op1), 32'h0);
        checkVal("mid rst addr", addr1, 32'h0);
        checkVal("mid rst busy", 32'(busy1), 32'h0);
        checkVal("mid rst abort", 32'(abort1), 32'h0);
        endFrame();
        for (int i = 0; i < 8; i++) begin
            sendEdge(64'h3BC4, 16, 2'd1, 3'd0, i);
            if (i == 3) begin
                checkVal("x2 op 3B", 32'(op1), 32'h3B);
                checkVal("x2 op_valid", 32'(opV1), 32'h1);
            end
        end
        checkVal("x2 op 3B dut2", 32'(op2), 32'h3B);
        checkVal("x2 op_valid dut2", 32'(opV2), 32'h1);
        endFrame();

        // Randomised frames: pin mode/length wiggle mid-frame, occasional reset
        for (int f = 0; f < 250; f++) begin
            logic [1:0] lm;
            logic [2:0] ab;
            lm = 2'($urandom_range(0, 3));
            ab = 3'($urandom_range(0, 7));
            L  = 1 << lm;
            b0 = 8'($urandom);
            b1 = ($urandom_range(0, 1) == 1) ? ~b0 : 8'($urandom);
            data = {b0, b1, 32'($urandom), 16'($urandom)};
            len = ($urandom_range(0, 1) == 1) ? 64 / L : $urandom_range(1, 64 / L);
            for (int i = 0; i < len; i++) begin
                logic [63:0] chunk;
                chunk = (data >> (64 - L * (i + 1))) & ((64'd1 << L) - 64'd1);
                if (i == 0)
                    applyStimulus(0, 1, 8'(chunk), lm, ab);
                else
                    applyStimulus($urandom_range(0, 99) < 2, 1, 8'(chunk) | (8'($urandom) & ~8'((9'd1 << L) - 9'd1)),
                                  2'($urandom), 3'($urandom));
            end
            for (int g = 0; g < int'($urandom_range(1, 2)); g++)
                applyStimulus(0, 0, 8'($urandom), 2'($urandom), 3'($urandom));
        end

        @(posedge sck);
        #1;
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
